ascii2hex_word: RTL and testbench

Stream parser converting ASCII hex text back into binary words; the inverse of the per-nibble hex-to-ASCII display path. Sits between a character source (serial receiver, simulated console) and any consumer of binary words, such as a memory loader or a debug-register writer. Accepts one character per cycle over a valid/ready handshake and accumulates hex digits. On each delimiter, emits a word with a digit count and an error flag over a second valid/ready handshake.

---
 rtl/tenyr_ascii_pkg.sv | 11 +
 rtl/ascii_hex_nibble.sv | 19 +
 rtl/ascii2hex_word.sv | 88 ++++++++
 tb/tb_ascii2hex_word.sv | 129 ++++++++++++
 4 files changed

// File: rtl/tenyr_ascii_pkg.sv
// tenyr_ascii: shared ASCII constants and parser state encoding.
package tenyr_ascii;
  localparam logic [7:0] ASC_SP  = 8'h20;
  localparam logic [7:0] ASC_TAB = 8'h09;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_0   = 8'h30;
  localparam logic [7:0] ASC_UA  = 8'h41;
  localparam logic [7:0] ASC_LA  = 8'h61;
  typedef enum logic [1:0] {A2H_IDLE, A2H_ACCUM, A2H_SKIP, A2H_EMIT} a2h_state_t;
endpackage

// File: rtl/ascii_hex_nibble.sv
// ascii_hex_nibble: classifies a character and decodes hex digits of either case.
module ascii_hex_nibble
  import tenyr_ascii::*;
(
  input  logic [7:0] char,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_delim
);
  logic is_dig, is_af;
  always_comb begin
    is_dig   = char >= ASC_0 && char <= ASC_0 + 8'd9;
    is_af    = (char >= ASC_UA && char <= ASC_UA + 8'd5) || (char >= ASC_LA && char <= ASC_LA + 8'd5);
    is_hex   = is_dig || is_af;
    // 'A' and 'a' both have low nibble 1, so +9 maps them to 10
    nibble   = is_dig ? char[3:0] : is_af ? char[3:0] + 4'd9 : 4'd0;
    is_delim = char == ASC_SP || char == ASC_TAB || char == ASC_LF || char == ASC_CR;
  end
endmodule

// File: rtl/ascii2hex_word.sv
// ascii2hex_word: parses delimiter-separated ASCII hex tokens into binary words.
module ascii2hex_word
  import tenyr_ascii::*;
#(
  parameter int WIDTH  = 32,
  parameter int MAXDIG = WIDTH / 4,
  localparam int CW    = $clog2(MAXDIG + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [CW-1:0]    out_ndigits,
  output logic             out_err
);
  localparam logic [CW-1:0] MAXC = CW'(MAXDIG);
  a2h_state_t state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH+3:0] shifted;
  logic [CW-1:0]    cnt, cnt_n;
  logic             err, err_n, xfer;
  logic [3:0]       nib;
  logic             is_hex, is_delim;

  ascii_hex_nibble u_nib (.char(in_char), .nibble(nib), .is_hex(is_hex), .is_delim(is_delim));

  assign in_ready    = state != A2H_EMIT;
  assign out_valid   = state == A2H_EMIT;
  assign out_word    = err ? '0 : acc;
  assign out_ndigits = cnt;
  assign out_err     = err;
  assign xfer        = in_valid && in_ready;
  assign shifted     = {acc, nib};

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    err_n   = err;
    case (state)
      A2H_IDLE:
        if (xfer && is_hex) begin
          acc_n   = WIDTH'(nib);
          cnt_n   = CW'(1);
          state_n = A2H_ACCUM;
        end else if (xfer && !is_delim) begin
          err_n   = 1'b1;
          state_n = A2H_SKIP;
        end
      A2H_ACCUM:
        if (xfer && is_delim) state_n = A2H_EMIT;
        else if (xfer && is_hex && cnt < MAXC) begin
          acc_n = shifted[WIDTH-1:0];
          cnt_n = cnt + CW'(1);
        end else if (xfer) begin
          err_n   = 1'b1;
          state_n = A2H_SKIP;
        end
      A2H_SKIP:
        if (xfer && is_delim) state_n = A2H_EMIT;
      A2H_EMIT:
        if (out_ready) begin
          acc_n   = '0;
          cnt_n   = '0;
          err_n   = 1'b0;
          state_n = A2H_IDLE;
        end
      default: state_n = A2H_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= A2H_IDLE;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
endmodule

// File: tb/tb_ascii2hex_word.sv
// tb_ascii2hex_word: directed streams with a queue scoreboard and a result monitor.
module tb_ascii2hex_word;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1, out_valid, in_ready, out_err;
  logic [7:0] in_char = 0;
  logic [31:0] out_word;
  logic [3:0] out_ndigits;
  int checks = 0, errors = 0;
  typedef struct packed {logic [31:0] w; logic [3:0] n; logic e;} res_t;
  res_t q[$];

  ascii2hex_word #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_ndigits(out_ndigits), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input byte c);
    int n = 0;
    in_valid = 1;
    in_char  = c;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 100) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic expect_res(input logic [31:0] w, input logic [3:0] n, input logic e);
    q.push_back('{w: w, n: n, e: e});
  endtask

  always @(negedge clk)
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious: got %0h/%0d/%0b expected no result", out_word, out_ndigits, out_err);
      end else begin
        chk("out_word", out_word, q[0].w);
        chk("out_ndigits", out_ndigits, q[0].n);
        chk("out_err", out_err, q[0].e);
        chk("in_ready_in_emit", in_ready, 0);
        if (out_ready) void'(q.pop_front());
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_ndigits", out_ndigits, 0);
    chk("rst_out_err", out_err, 0);
    @(posedge clk);
    #1 reset = 0;

    expect_res(32'h00001A3F, 4, 0);
    send_str("1A3f\n");
    chk("latency_valid", out_valid, 1);

    expect_res(32'hDEADBEEF, 8, 0);
    expect_res(32'h00000007, 1, 0);
    send_str("  \t DEADbeef \r\n7 ");

    expect_res(32'h0, 8, 1);
    expect_res(32'h42, 2, 0);
    send_str("123456789 42 ");

    expect_res(32'h0, 2, 1);
    send_str("12G4 ");

    out_ready = 0;
    expect_res(32'hAB, 2, 0);
    expect_res(32'hCD, 2, 0);
    fork
      send_str("AB CD ");
      begin
        int n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_valid_seen", out_valid, 1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join

    send_str("FF");
    #1 reset = 1;
    #1;
    chk("async_in_ready", in_ready, 1);
    chk("async_out_valid", out_valid, 0);
    chk("async_out_word", out_word, 0);
    chk("async_out_ndigits", out_ndigits, 0);
    chk("async_out_err", out_err, 0);
    @(posedge clk);
    #1 reset = 0;
    expect_res(32'h3, 1, 0);
    send_str("3 ");

    repeat (5) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
